// File: rtl/coso_ro_tuner.sv
// Closed-loop configuration sequencer for a COSO ring-oscillator pair: sweeps RO1
// configurations, averages the beat period of each, and locks on the first in-window one.
module coso_ro_tuner #(
   parameter int LENGTH     = 3,
   parameter int SETTLE_CYC = 256,
   parameter int BEATS_LOG2 = 3,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [2*LENGTH-1:0] sel0_in,
   input  logic [CNT_W-1:0]    target_lo,
   input  logic [CNT_W-1:0]    target_hi,
   input  logic                beat_sync,
   output logic                ro_en,
   output logic [2*LENGTH-1:0] sel0,
   output logic [2*LENGTH-1:0] sel1,
   output logic                busy,
   output logic                locked,
   output logic                fail,
   output logic [CNT_W-1:0]    beat_len,
   output logic                beat_valid
);

   localparam int SW = 2*LENGTH;
   localparam int AW = CNT_W + BEATS_LOG2;
   localparam int TW = $clog2(SETTLE_CYC + 1);
   localparam int BW = BEATS_LOG2 + 1;

   localparam logic [TW-1:0]    TIMER_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [BW-1:0]    BEATS_LAST = BW'((1 << BEATS_LOG2) - 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_SYNC, S_MEASURE, S_EVAL, S_LOCKED, S_FAIL
   } state_t;

   state_t            state;
   logic              beat_d;
   logic              timeout;
   logic [TW-1:0]     timer;
   logic [CNT_W-1:0]  cnt;
   logic [AW-1:0]     acc;
   logic [BW-1:0]     beats;

   logic              rise;
   logic [CNT_W-1:0]  period;
   logic [AW-1:0]     acc_shift;
   logic [CNT_W-1:0]  avg;
   logic              hit;

   // cnt is capped at all-ones minus one, so period (cnt+1) always fits in CNT_W bits.
   assign rise      = beat_sync & ~beat_d;
   assign period    = cnt + 1'b1;
   assign acc_shift = acc >> BEATS_LOG2;
   assign avg       = acc_shift[CNT_W-1:0];
   assign hit       = !timeout && (avg >= target_lo) && (avg <= target_hi);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         beat_d     <= 1'b0;
         timeout    <= 1'b0;
         timer      <= '0;
         cnt        <= '0;
         acc        <= '0;
         beats      <= '0;
         ro_en      <= 1'b0;
         sel0       <= '0;
         sel1       <= '0;
         busy       <= 1'b0;
         locked     <= 1'b0;
         fail       <= 1'b0;
         beat_len   <= '0;
         beat_valid <= 1'b0;
      end else begin
         beat_d     <= beat_sync;
         beat_valid <= 1'b0;
         if (abort) begin
            state  <= S_IDLE;
            ro_en  <= 1'b0;
            busy   <= 1'b0;
            locked <= 1'b0;
            fail   <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_LOCKED, S_FAIL: begin
                  if (start) begin
                     sel0   <= sel0_in;
                     sel1   <= '0;
                     ro_en  <= 1'b1;
                     busy   <= 1'b1;
                     locked <= 1'b0;
                     fail   <= 1'b0;
                     timer  <= '0;
                     state  <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (timer == TIMER_LAST) state <= S_SYNC;
                  else                     timer <= timer + 1'b1;
               end
               S_SYNC: begin
                  if (rise) begin
                     cnt     <= '0;
                     acc     <= '0;
                     beats   <= '0;
                     timeout <= 1'b0;
                     state   <= S_MEASURE;
                  end
               end
               S_MEASURE: begin
                  if (rise) begin
                     acc   <= acc + AW'(period);
                     cnt   <= '0;
                     beats <= beats + 1'b1;
                     if (beats == BEATS_LAST) state <= S_EVAL;
                  end else if (cnt == CNT_LAST) begin
                     timeout <= 1'b1;
                     state   <= S_EVAL;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_EVAL: begin
                  beat_valid <= 1'b1;
                  beat_len   <= timeout ? '1 : avg;
                  if (hit) begin
                     locked <= 1'b1;
                     busy   <= 1'b0;
                     state  <= S_LOCKED;
                  end else if (sel1 == {SW{1'b1}}) begin
                     fail   <= 1'b1;
                     busy   <= 1'b0;
                     ro_en  <= 1'b0;
                     state  <= S_FAIL;
                  end else begin
                     sel1   <= sel1 + 1'b1;
                     timer  <= '0;
                     state  <= S_SETTLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_coso_ro_tuner.sv
// Directed bench for coso_ro_tuner: a behavioural RO pair produces a beat whose period
// depends on sel1; each task checks beat_len / status against hand-computed values.
module tb_coso_ro_tuner;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [1:0] sel0_in;
   logic [7:0] target_lo;
   logic [7:0] target_hi;
   logic       beat_sync;
   logic       ro_en;
   logic [1:0] sel0;
   logic [1:0] sel1;
   logic       busy;
   logic       locked;
   logic       fail;
   logic [7:0] beat_len;
   logic       beat_valid;

   int checks = 0;
   int errors = 0;

   logic [7:0] periods [4];
   bit         hold_mode = 0;

   coso_ro_tuner #(.LENGTH(1), .SETTLE_CYC(4), .BEATS_LOG2(1), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel0_in(sel0_in),
      .target_lo(target_lo), .target_hi(target_hi), .beat_sync(beat_sync),
      .ro_en(ro_en), .sel0(sel0), .sel1(sel1), .busy(busy), .locked(locked),
      .fail(fail), .beat_len(beat_len), .beat_valid(beat_valid)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Behavioural RO pair: one-cycle beat pulse every periods[sel1] cycles; in hold mode
   // the beat stays high after its first pulse until sel1 changes.
   initial begin : beat_gen
      int ph;
      bit seen;
      logic [1:0] last_sel;
      ph = 0; seen = 0; last_sel = 0; beat_sync = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!ro_en || sel1 != last_sel) begin
            ph = 0; seen = 0; beat_sync = 0;
         end else if (hold_mode && seen) begin
            beat_sync = 1;
         end else begin
            ph++;
            if (ph >= int'(periods[sel1])) begin
               ph = 0; seen = 1; beat_sync = 1;
            end else begin
               beat_sync = 0;
            end
         end
         last_sel = sel1;
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_valid(output logic [7:0] len, output bit ok);
      ok = 0;
      len = '0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (beat_valid) begin
            len = beat_len;
            ok = 1;
            break;
         end
      end
   endtask

   task automatic expect_len(input string name, input logic [7:0] exp);
      logic [7:0] len;
      bit ok;
      wait_valid(len, ok);
      checks++;
      if (!ok || len !== exp) begin
         errors++;
         $display("FAIL %s: beat_len=%0d seen=%0d, expected %0d", name, len, ok, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 0; start = 0; abort = 0; sel0_in = 0; target_lo = 0; target_hi = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ro_en, sel0, sel1, busy, locked, fail, beat_len, beat_valid} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, expected 0",
                  {ro_en, sel0, sel1, busy, locked, fail, beat_len, beat_valid});
      end
      rst_n = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (ro_en !== 0 || busy !== 0) begin
         errors++;
         $display("FAIL reset_idle: ro_en=%b busy=%b, expected 0 0", ro_en, busy);
      end
   endtask

   task automatic test_immediate();
      periods[0] = 10; periods[1] = 10; periods[2] = 10; periods[3] = 10;
      target_lo = 9; target_hi = 11; sel0_in = 2'b10;
      do_start();
      checks++;
      if (busy !== 1 || ro_en !== 1) begin
         errors++;
         $display("FAIL imm_busy: busy=%b ro_en=%b, expected 1 1", busy, ro_en);
      end
      expect_len("imm_len", 8'd10);
      checks++;
      if (locked !== 1 || sel1 !== 2'd0 || ro_en !== 1 || busy !== 0 || sel0 !== 2'b10) begin
         errors++;
         $display("FAIL imm_lock: locked=%b sel1=%0d ro_en=%b busy=%b sel0=%0d, expected 1 0 1 0 2",
                  locked, sel1, ro_en, busy, sel0);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (beat_valid !== 0 || locked !== 1) begin
         errors++;
         $display("FAIL imm_hold: beat_valid=%b locked=%b, expected 0 1", beat_valid, locked);
      end
   endtask

   task automatic test_sweep();
      periods[0] = 20; periods[1] = 18; periods[2] = 12; periods[3] = 30;
      target_lo = 11; target_hi = 13; sel0_in = 2'b01;
      do_start();
      checks++;
      if (locked !== 0 || busy !== 1 || sel1 !== 2'd0) begin
         errors++;
         $display("FAIL sweep_restart: locked=%b busy=%b sel1=%0d, expected 0 1 0", locked, busy, sel1);
      end
      expect_len("sweep_len0", 8'd20);
      expect_len("sweep_len1", 8'd18);
      expect_len("sweep_len2", 8'd12);
      checks++;
      if (locked !== 1 || sel1 !== 2'd2 || sel0 !== 2'b01 || fail !== 0) begin
         errors++;
         $display("FAIL sweep_lock: locked=%b sel1=%0d sel0=%0d fail=%b, expected 1 2 1 0",
                  locked, sel1, sel0, fail);
      end
   endtask

   task automatic test_exhaust();
      target_lo = 50; target_hi = 60;
      do_start();
      expect_len("exh_len0", 8'd20);
      expect_len("exh_len1", 8'd18);
      expect_len("exh_len2", 8'd12);
      expect_len("exh_len3", 8'd30);
      checks++;
      if (fail !== 1 || ro_en !== 0 || sel1 !== 2'd3 || busy !== 0 || locked !== 0) begin
         errors++;
         $display("FAIL exh_fail: fail=%b ro_en=%b sel1=%0d busy=%b locked=%b, expected 1 0 3 0 0",
                  fail, ro_en, sel1, busy, locked);
      end
   endtask

   task automatic test_timeout();
      periods[0] = 10; periods[1] = 10; periods[2] = 10; periods[3] = 10;
      target_lo = 9; target_hi = 11;
      hold_mode = 1;
      do_start();
      checks++;
      if (fail !== 0 || busy !== 1) begin
         errors++;
         $display("FAIL to_restart: fail=%b busy=%b, expected 0 1", fail, busy);
      end
      expect_len("to_len0", 8'hFF);
      expect_len("to_len1", 8'hFF);
      expect_len("to_len2", 8'hFF);
      expect_len("to_len3", 8'hFF);
      checks++;
      if (fail !== 1 || sel1 !== 2'd3 || locked !== 0 || ro_en !== 0) begin
         errors++;
         $display("FAIL to_fail: fail=%b sel1=%0d locked=%b ro_en=%b, expected 1 3 0 0",
                  fail, sel1, locked, ro_en);
      end
      hold_mode = 0;
   endtask

   task automatic test_abort();
      target_lo = 50; target_hi = 60; sel0_in = 2'b11;
      do_start();
      repeat (16) @(negedge clk);
      checks++;
      if (busy !== 1 || ro_en !== 1) begin
         errors++;
         $display("FAIL abort_pre: busy=%b ro_en=%b, expected 1 1", busy, ro_en);
      end
      abort = 1;
      @(negedge clk);
      abort = 0;
      checks++;
      if (ro_en !== 0 || busy !== 0 || fail !== 0 || sel1 !== 2'd0 || sel0 !== 2'b11) begin
         errors++;
         $display("FAIL abort_stop: ro_en=%b busy=%b fail=%b sel1=%0d sel0=%0d, expected 0 0 0 0 3",
                  ro_en, busy, fail, sel1, sel0);
      end
      start = 1; abort = 1;
      @(negedge clk);
      start = 0; abort = 0;
      repeat (10) @(negedge clk);
      checks++;
      if (ro_en !== 0 || busy !== 0 || beat_valid !== 0) begin
         errors++;
         $display("FAIL abort_wins: ro_en=%b busy=%b beat_valid=%b, expected 0 0 0",
                  ro_en, busy, beat_valid);
      end
   endtask

   task automatic test_reset_measure();
      do_start();
      repeat (16) @(negedge clk);
      checks++;
      if (busy !== 1 || beat_len !== 8'hFF || sel0 !== 2'b11) begin
         errors++;
         $display("FAIL rst_pre: busy=%b beat_len=%h sel0=%0d, expected 1 ff 3", busy, beat_len, sel0);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({ro_en, sel0, sel1, busy, locked, fail, beat_len, beat_valid} !== 16'h0) begin
         errors++;
         $display("FAIL rst_async: got %h, expected 0",
                  {ro_en, sel0, sel1, busy, locked, fail, beat_len, beat_valid});
      end
      @(negedge clk);
      rst_n = 1;
      repeat (20) @(negedge clk);
      checks++;
      if (ro_en !== 0 || busy !== 0 || beat_valid !== 0) begin
         errors++;
         $display("FAIL rst_idle: ro_en=%b busy=%b beat_valid=%b, expected 0 0 0",
                  ro_en, busy, beat_valid);
      end
   endtask

   initial begin
      periods[0] = 10; periods[1] = 10; periods[2] = 10; periods[3] = 10;
      test_reset();
      test_immediate();
      test_sweep();
      test_exhaust();
      test_timeout();
      test_abort();
      test_reset_measure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
